rr_arbiter8: RTL and testbench

Eight-requester round-robin arbiter with a registered one-hot grant and a valid/ready handshake. It sits directly upstream of the bit-position encoder, and its `grant` bus drives the encoder's 8-bit one-hot `binary_number` input. The encoder therefore always sees either all-zero or exactly one set bit. A per-requester burst counter lets the current winner keep the grant for up to `MAX_BURST` consecutive accepted transfers before priority rotates.

---
 rtl/rr_arbiter8_if.sv | 30 +++
 rtl/rr_arbiter8.sv | 175 +++++++++++++++++
 tb/tb_rr_arbiter8.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if
//   Grant handshake bundle between the requesters, the arbiter and the
//   downstream consumer.
//   req         : 8-bit level-sensitive request vector, bit i = requester i
//   grant_ready : downstream accepts the grant currently offered
//   grant       : one-hot grant, 8'h00 when nothing is offered
//   grant_valid : a grant is being offered
//   Modports:
//     master - the requester/consumer side, which drives req and grant_ready
//     slave  - the arbiter, which drives grant and grant_valid
interface rr_arbiter8_if;
   logic [7:0] req;
   logic       grant_ready;
   logic [7:0] grant;
   logic       grant_valid;

   modport master (
      output req,
      output grant_ready,
      input  grant,
      input  grant_valid
   );

   modport slave (
      input  req,
      input  grant_ready,
      output grant,
      output grant_valid
   );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8
//   Eight-requester round-robin arbiter. The grant is registered and one-hot,
//   and it is offered over a valid/ready handshake. The current winner keeps
//   the grant for up to MAX_BURST consecutive accepted transfers while it
//   keeps requesting. Priority then rotates so that the requester just served
//   becomes the lowest-priority one.
//   Parameters:
//     MAX_BURST : 1..15, the largest number of back-to-back accepts that one
//                 requester can receive
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : rr_arbiter8_if.slave (req, grant_ready in; grant, grant_valid out)
//   Every output comes straight from a flop. No combinational path runs from
//   req or grant_ready to any output.
module rr_arbiter8 #(
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   rr_arbiter8_if.slave bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   state_t     state_reg, state_next;
   logic [2:0] ptr_reg, ptr_next;
   logic [2:0] gidx_reg, gidx_next;
   logic [3:0] burst_cnt_reg, burst_cnt_next;
   logic [7:0] grant_reg, grant_next;
   logic       grant_valid_reg, grant_valid_next;

   // ------------------------------------------------------------------
   // Priority search
   // A single search engine serves both cases. In IDLE the scan starts at
   // ptr. In OFFER the only search whose result is used is the one after a
   // rotation, and that scan starts at gidx+1. The scan starts there because
   // ptr is still being updated in that cycle. After a rotation that finds
   // no requester, the state goes to IDLE with ptr already at gidx+1. The
   // two cases therefore always agree.
   // ------------------------------------------------------------------
   logic [2:0] search_base;
   logic [7:0] req_rot;
   logic       search_hit;
   logic [2:0] search_off;
   logic [2:0] search_idx;
   logic [7:0] search_onehot;

   assign search_base = (state_reg == OFFER) ? (gidx_reg + 3'd1) : ptr_reg;

   // Rotate req so that bit 0 of req_rot is the highest-priority requester.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_rot
         assign req_rot[gi] = bus.req[3'(search_base + 3'(gi))];
      end
   endgenerate

   // The loop runs downwards, so the lowest set bit of req_rot is assigned
   // last and wins.
   always_comb begin
      search_hit = 1'b0;
      search_off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (req_rot[i]) begin
            search_hit = 1'b1;
            search_off = 3'(i);
         end
      end
   end

   assign search_idx = search_base + search_off;

   generate
      for (gi = 0; gi < 8; gi++) begin : g_onehot
         assign search_onehot[gi] = (search_idx == 3'(gi));
      end
   endgenerate

   // ------------------------------------------------------------------
   // Burst accounting
   // The comparison is done at 5 bits so that burst_cnt+1 cannot wrap.
   // ------------------------------------------------------------------
   logic       handshake;
   logic       keep_grant;

   assign handshake  = grant_valid_reg & bus.grant_ready;
   assign keep_grant = bus.req[gidx_reg] &
                       (({1'b0, burst_cnt_reg} + 5'd1) < 5'(MAX_BURST));

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next       = state_reg;
      ptr_next         = ptr_reg;
      gidx_next        = gidx_reg;
      burst_cnt_next   = burst_cnt_reg;
      grant_next       = grant_reg;
      grant_valid_next = grant_valid_reg;

      case (state_reg)
         IDLE: begin
            if (search_hit) begin
               gidx_next        = search_idx;
               grant_next       = search_onehot;
               grant_valid_next = 1'b1;
               state_next       = OFFER;
            end
         end

         OFFER: begin
            // Without a handshake the offer is held, even if req[gidx]
            // drops. A grant is never retracted.
            if (handshake) begin
               if (keep_grant) begin
                  burst_cnt_next = burst_cnt_reg + 4'd1;
               end else begin
                  ptr_next       = gidx_reg + 3'd1;
                  burst_cnt_next = 4'd0;
                  if (search_hit) begin
                     // A new grant is loaded in the same cycle, so no
                     // bubble appears between grants.
                     gidx_next  = search_idx;
                     grant_next = search_onehot;
                  end else begin
                     grant_next       = 8'h00;
                     grant_valid_next = 1'b0;
                     state_next       = IDLE;
                  end
               end
            end
         end

         default: begin
            state_next       = IDLE;
            grant_next       = 8'h00;
            grant_valid_next = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         ptr_reg         <= 3'd0;
         gidx_reg        <= 3'd0;
         burst_cnt_reg   <= 4'd0;
         grant_reg       <= 8'h00;
         grant_valid_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         ptr_reg         <= ptr_next;
         gidx_reg        <= gidx_next;
         burst_cnt_reg   <= burst_cnt_next;
         grant_reg       <= grant_next;
         grant_valid_reg <= grant_valid_next;
      end
   end

   assign bus.grant       = grant_reg;
   assign bus.grant_valid = grant_valid_reg;

   // The downstream encoder relies on this: grant is one-hot or zero, and
   // grant is nonzero exactly when grant_valid is set.
   grant_shape_a : assert property (@(posedge clk) disable iff (!rst_n)
      ($onehot0(grant_reg) && ((grant_reg != 8'h00) == grant_valid_reg)));

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8
//   Directed bench for rr_arbiter8. Instance dut_a uses MAX_BURST=4 and
//   instance dut_b uses MAX_BURST=1. Both share the clock and reset.
//   Inputs change 1 time unit after a rising edge, and outputs are sampled
//   at that same point, so each check sees the result of the edge just past.
module tb_rr_arbiter8;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   rr_arbiter8_if ifa ();
   rr_arbiter8_if ifb ();

   rr_arbiter8 #(.MAX_BURST(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   rr_arbiter8 #(.MAX_BURST(1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      ifa.req = 8'h00; ifa.grant_ready = 1'b0;
      ifb.req = 8'h00; ifb.grant_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Asynchronous reset taken in the middle of an offer, then 10 idle cycles
   // with grant_ready high, which must be ignored while nothing is offered.
   task automatic test_reset();
      do_reset();
      ifa.req = 8'h04; ifa.grant_ready = 1'b0;
      step();
      vectors++;
      if (ifa.grant !== 8'h04 || ifa.grant_valid !== 1'b1) begin
         $display("FAIL reset_pre: grant=%h valid=%b expected grant=04 valid=1", ifa.grant, ifa.grant_valid);
         miscompares++;
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (ifa.grant !== 8'h00 || ifa.grant_valid !== 1'b0) begin
         $display("FAIL reset_async: grant=%h valid=%b expected grant=00 valid=0", ifa.grant, ifa.grant_valid);
         miscompares++;
      end
      ifa.req = 8'h00; ifa.grant_ready = 1'b1;
      #2 rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         vectors++;
         if (ifa.grant !== 8'h00 || ifa.grant_valid !== 1'b0) begin
            $display("FAIL reset_idle[%0d]: grant=%h valid=%b expected grant=00 valid=0", k, ifa.grant, ifa.grant_valid);
            miscompares++;
         end
      end
      $display("test_reset done");
   endtask

   // A lone requester keeps the grant across the burst-limit rotation
   // because the search wraps back to it with no bubble.
   task automatic test_single();
      do_reset();
      ifa.req = 8'h04; ifa.grant_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         vectors++;
         if (ifa.grant !== 8'h04 || ifa.grant_valid !== 1'b1) begin
            $display("FAIL single[%0d]: grant=%h valid=%b expected grant=04 valid=1", k, ifa.grant, ifa.grant_valid);
            miscompares++;
         end
      end
      $display("test_single done");
   endtask

   task automatic test_backpressure();
      do_reset();
      ifa.req = 8'h01; ifa.grant_ready = 1'b0;
      step();
      vectors++;
      if (ifa.grant !== 8'h01 || ifa.grant_valid !== 1'b1) begin
         $display("FAIL bp_offer: grant=%h valid=%b expected grant=01 valid=1", ifa.grant, ifa.grant_valid);
         miscompares++;
      end
      for (int k = 0; k < 5; k++) begin
         if (k == 2) ifa.req = 8'h00;
         step();
         vectors++;
         if (ifa.grant !== 8'h01 || ifa.grant_valid !== 1'b1) begin
            $display("FAIL bp_hold[%0d]: grant=%h valid=%b expected grant=01 valid=1", k, ifa.grant, ifa.grant_valid);
            miscompares++;
         end
      end
      ifa.grant_ready = 1'b1;
      step();
      ifa.grant_ready = 1'b0;
      vectors++;
      if (ifa.grant !== 8'h00 || ifa.grant_valid !== 1'b0) begin
         $display("FAIL bp_accept: grant=%h valid=%b expected grant=00 valid=0", ifa.grant, ifa.grant_valid);
         miscompares++;
      end
      step();
      vectors++;
      if (ifa.grant !== 8'h00 || ifa.grant_valid !== 1'b0) begin
         $display("FAIL bp_after: grant=%h valid=%b expected grant=00 valid=0", ifa.grant, ifa.grant_valid);
         miscompares++;
      end
      $display("test_backpressure done");
   endtask

   task automatic test_rotation();
      logic [7:0] exp_seq [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
      do_reset();
      ifb.req = 8'hFF; ifb.grant_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         vectors++;
         if (ifb.grant !== exp_seq[k] || ifb.grant_valid !== 1'b1) begin
            $display("FAIL rotation[%0d]: grant=%h valid=%b expected grant=%h valid=1", k, ifb.grant, ifb.grant_valid, exp_seq[k]);
            miscompares++;
         end
      end
      $display("test_rotation done");
   endtask

   task automatic test_burst_limit();
      logic [7:0] exp_seq [12] = '{8'h01, 8'h01, 8'h01, 8'h01,
                                   8'h80, 8'h80, 8'h80, 8'h80,
                                   8'h01, 8'h01, 8'h01, 8'h01};
      do_reset();
      ifa.req = 8'h81; ifa.grant_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         vectors++;
         if (ifa.grant !== exp_seq[k] || ifa.grant_valid !== 1'b1) begin
            $display("FAIL burst[%0d]: grant=%h valid=%b expected grant=%h valid=1", k, ifa.grant, ifa.grant_valid, exp_seq[k]);
            miscompares++;
         end
      end
      $display("test_burst_limit done");
   endtask

   // grant_ready alternates 1/0. The grant must change only after a cycle in
   // which it was accepted, and the accepted grants alternate 02/08.
   task automatic test_toggle_fairness();
      logic [7:0] exp_seq [8] = '{8'h08, 8'h08, 8'h02, 8'h02, 8'h08, 8'h08, 8'h02, 8'h02};
      do_reset();
      ifb.req = 8'h0A; ifb.grant_ready = 1'b0;
      step();
      vectors++;
      if (ifb.grant !== 8'h02 || ifb.grant_valid !== 1'b1) begin
         $display("FAIL toggle_first: grant=%h valid=%b expected grant=02 valid=1", ifb.grant, ifb.grant_valid);
         miscompares++;
      end
      for (int k = 0; k < 8; k++) begin
         ifb.grant_ready = (k % 2 == 0);
         step();
         vectors++;
         if (ifb.grant !== exp_seq[k] || ifb.grant_valid !== 1'b1) begin
            $display("FAIL toggle[%0d]: grant=%h valid=%b expected grant=%h valid=1", k, ifb.grant, ifb.grant_valid, exp_seq[k]);
            miscompares++;
         end
      end
      ifb.grant_ready = 1'b0;
      $display("test_toggle_fairness done");
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      ifa.req = 8'h00; ifa.grant_ready = 1'b0;
      ifb.req = 8'h00; ifb.grant_ready = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_rotation();
      test_burst_limit();
      test_toggle_fairness();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
